// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps mux4x1 selects through a..d, settles, samples and packs a 4-bit frame
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid,
  output logic [7:0] scan_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [2:0] shadow;
  logic [1:0] ch;
  assign ch = {s0, s1};
  // Scan FSM: settle on each channel, shift samples a..c into the shadow, emit the frame on d
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {s0, s1} <= 2'b00;
      busy <= 1'b0;
      frame <= 4'd0;
      frame_valid <= 1'b0;
      scan_count <= 8'd0;
      cnt <= '0;
      shadow <= 3'd0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SETTLE;
          {s0, s1} <= 2'b00;
          cnt <= RELOAD;
          busy <= 1'b1;
        end
        SETTLE: if (cnt != '0) cnt <= cnt - CNT_W'(1);
                else state <= SAMPLE;
        SAMPLE: begin
          cnt <= RELOAD;
          if (ch != 2'd3) begin
            shadow <= {mux_out, shadow[2:1]};
            {s0, s1} <= ch + 2'd1;
            state <= SETTLE;
          end else begin
            frame <= {mux_out, shadow};
            frame_valid <= 1'b1;
            scan_count <= scan_count + 8'd1;
            state <= cont ? SETTLE : IDLE;
            busy <= cont;
            if (cont) {s0, s1} <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: scoreboarded random scans against a channel-value reference model
module tb_mux_scan_sequencer;
  typedef struct {
    logic [3:0] f;
    logic [7:0] c;
    int t;
  } exp_t;
  logic clk = 0, rst = 1;
  logic start2 = 0, cont2 = 0, start1 = 0, cont1 = 0;
  logic [3:0] in2 = 0, in1 = 0;
  logic s0_2, s1_2, busy2, fv2, s0_1, s1_1, busy1, fv1, mo2, mo1;
  logic [3:0] fr2, fr1;
  logic [7:0] sc2, sc1;
  logic [7:0] cnt2 = 0;
  logic [3:0] pat [0:7];
  int errors = 0, checks = 0, cyc = 0, k6;
  exp_t q2[$], q1[$];

  assign mo2 = in2[{s0_2, s1_2}];
  assign mo1 = in1[{s0_1, s1_1}];

  mux_scan_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cont(cont2), .mux_out(mo2),
    .s0(s0_2), .s1(s1_2), .busy(busy2), .frame(fr2), .frame_valid(fv2), .scan_count(sc2));

  mux_scan_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .mux_out(mo1),
    .s0(s0_1), .s1(s1_1), .busy(busy1), .frame(fr1), .frame_valid(fv1), .scan_count(sc1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon2
    exp_t e;
    if (fv2 === 1'b1) begin
      if (q2.size() == 0) chk("frame_valid2 unexpected", fv2, 0);
      else begin
        e = q2.pop_front();
        chk("frame2", fr2, e.f);
        chk("scan_count2", sc2, e.c);
        chk("pulse_time2", cyc, e.t);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (fv1 === 1'b1) begin
      if (q1.size() == 0) chk("frame_valid1 unexpected", fv1, 0);
      else begin
        e = q1.pop_front();
        chk("frame1", fr1, e.f);
        chk("scan_count1", sc1, e.c);
        chk("pulse_time1", cyc, e.t);
      end
    end
  end

  task automatic scans2(input int n, input bit poke);
    int k, drop;
    exp_t e;
    drop = $urandom_range(1, 10);
    @(negedge clk);
    in2 = pat[0];
    start2 = 1;
    cont2 = (n > 1);
    k = cyc + 1;
    for (int i = 0; i < n; i++) begin
      e.f = pat[i];
      e.c = 8'(cnt2 + 8'(i) + 8'd1);
      e.t = k + 12 * (i + 1);
      q2.push_back(e);
    end
    cnt2 = 8'(cnt2 + 8'(n));
    for (int j = 0; j < 12 * n; j++) begin
      @(negedge clk);
      if (j == 0) start2 = 0;
      chk("sel2", {s0_2, s1_2}, (j % 12) / 3);
      chk("busy2", busy2, 1);
      if (poke) start2 = (j == 5);
      if (j > 0 && j % 12 == 0) in2 = pat[j / 12];
      if (n > 1 && j == 12 * (n - 1) + drop) cont2 = 0;
    end
    @(negedge clk);
    chk("busy2 after scan", busy2, 0);
    repeat (15) @(negedge clk);
    chk("busy2 idle", busy2, 0);
    chk("pending2", q2.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst s0_2", s0_2, 0); chk("rst s1_2", s1_2, 0); chk("rst busy2", busy2, 0);
    chk("rst frame2", fr2, 0); chk("rst fv2", fv2, 0); chk("rst sc2", sc2, 0);
    chk("rst s0_1", s0_1, 0); chk("rst s1_1", s1_1, 0); chk("rst busy1", busy1, 0);
    chk("rst frame1", fr1, 0); chk("rst fv1", fv1, 0); chk("rst sc1", sc1, 0);
    rst = 0;
    pat[0] = 4'b1101;
    scans2(1, 0);
    pat[0] = 4'b1101; pat[1] = 4'b0101;
    scans2(2, 0);
    pat[0] = 4'($urandom);
    scans2(1, 1);
    for (int i = 0; i < 6; i++) pat[i] = 4'($urandom);
    scans2(6, 0);
    for (int r = 0; r < 3; r++) begin
      pat[0] = 4'($urandom);
      scans2($urandom_range(1, 3), r[0]);
    end
    @(negedge clk);
    in2 = 4'($urandom);
    start2 = 1;
    @(negedge clk);
    start2 = 0;
    repeat (6) @(negedge clk);
    chk("sel2 before reset", {s0_2, s1_2}, 2);
    rst = 1;
    start2 = 1;
    @(negedge clk);
    chk("midrst s0_2", s0_2, 0); chk("midrst s1_2", s1_2, 0); chk("midrst busy2", busy2, 0);
    chk("midrst frame2", fr2, 0); chk("midrst fv2", fv2, 0); chk("midrst sc2", sc2, 0);
    rst = 0;
    start2 = 0;
    cnt2 = 0;
    repeat (20) @(negedge clk);
    chk("busy2 after midrst", busy2, 0);
    @(negedge clk);
    in1 = 4'($urandom);
    start1 = 1;
    cont1 = 1;
    k6 = cyc + 1;
    e.f = in1; e.c = 8'd1; e.t = k6 + 8;
    q1.push_back(e);
    for (int j = 0; j < 2048; j++) begin
      @(negedge clk);
      if (j == 0) start1 = 0;
      chk("sel1", {s0_1, s1_1}, (j % 8) / 2);
      chk("busy1", busy1, 1);
      if (j > 0 && j % 8 == 0) begin
        in1 = 4'($urandom);
        e.f = in1; e.c = 8'(j / 8 + 1); e.t = k6 + j + 8;
        q1.push_back(e);
      end
      if (j == 8 * 255 + 3) cont1 = 0;
    end
    @(negedge clk);
    chk("busy1 after run", busy1, 0);
    chk("sc1 wrapped", sc1, 0);
    repeat (10) @(negedge clk);
    chk("pending1", q1.size(), 0);
    chk("pending2 final", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
